// File: rtl/mem_access_ctrl.sv
// Request/response front end for the on-chip SRAM-style memory: accepts single-word
// read/write requests, strobes the memory for one cycle, waits out read latency, returns a response.
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int SIZE    = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [9:0]        mem_address,
    output logic [15:0]       mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [15:0]       mem_readout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] SIZE_L   = (ADDR_W+1)'(SIZE);
    localparam logic [1:0]      CNT_INIT = 2'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rden_q, rden_d;
    logic        wren_q, wren_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rden_d      = rden_q;
        wren_d      = wren_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Out-of-range requests never reach the memory pins.
                    if ({1'b0, req_addr} < SIZE_L) begin
                        addr_d  = req_addr[9:0];
                        data_d  = req_wdata;
                        rden_d  = ~req_we;
                        wren_d  = req_we;
                        state_d = ACCESS;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ACCESS: begin
                rden_d = 1'b0;
                wren_d = 1'b0;
                if (wren_q) begin
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rsp_rdata_d = mem_readout;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_rden    = rden_q;
    assign mem_wren    = wren_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Drives two controllers (LATENCY=1 and LATENCY=3) with identical requests and checks
// each against a transaction-level model of the memory and the expected response timing.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        preload;
    logic        req_valid, req_we, rsp_ready;
    logic [15:0] req_addr, req_wdata;

    logic [1:0]  req_ready_w, rsp_valid_w, rsp_err_w, rden_w, wren_w, busy_w;
    logic [15:0] rsp_rdata_w [2];
    logic [15:0] mem_data_w [2];
    logic [15:0] readout_w [2];
    logic [9:0]  mem_address_w [2];

    logic [15:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] mem [1024];
        logic [15:0] pipe [4];

        mem_access_ctrl #(.ADDR_W(16), .SIZE(256), .LATENCY(LAT)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid   (req_valid),
            .req_ready   (req_ready_w[g]),
            .req_we      (req_we),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .rsp_valid   (rsp_valid_w[g]),
            .rsp_ready   (rsp_ready),
            .rsp_rdata   (rsp_rdata_w[g]),
            .rsp_err     (rsp_err_w[g]),
            .mem_address (mem_address_w[g]),
            .mem_data    (mem_data_w[g]),
            .mem_rden    (rden_w[g]),
            .mem_wren    (wren_w[g]),
            .mem_readout (readout_w[g]),
            .busy        (busy_w[g])
        );

        // Memory samples strobes at the edge closing ACCESS; readout appears LAT edges later.
        always @(posedge clk) begin
            if (preload) begin
                for (int i = 0; i < 1024; i++) mem[i] <= (i < 256) ? ref_mem[i] : 16'h0;
            end else begin
                if (wren_w[g]) mem[mem_address_w[g]] <= mem_data_w[g];
                if (rden_w[g]) pipe[0] <= mem[mem_address_w[g]];
            end
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign readout_w[g] = pipe[LAT-1];
    end

    // One request through both DUTs; response is taken from edge rdy_from onward.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input int rdy_from, input string tag);
        int e[2], c[2], min_c, max_c, lat;
        bit inr;
        logic [15:0] exp_rd;
        inr    = (addr < 16'd256);
        exp_rd = (inr && !we) ? ref_mem[addr[7:0]] : 16'h0;
        for (int d = 0; d < 2; d++) begin
            lat  = (d == 0) ? 1 : 3;
            e[d] = !inr ? 0 : (we ? 1 : 1 + lat);
            c[d] = (e[d] + 1 > rdy_from) ? e[d] + 1 : rdy_from;
        end
        min_c = (c[0] < c[1]) ? c[0] : c[1];
        max_c = (c[0] > c[1]) ? c[0] : c[1];

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        rsp_ready = (rdy_from <= 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready_w[d] !== 1'b1) begin
                errors++; $display("FAIL %s dut%0d req_ready got %b want 1", tag, d, req_ready_w[d]);
            end
        end
        for (int k = 0; k <= max_c; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bit in_txn, exp_v;
                in_txn = (k < c[d]);
                exp_v  = (k >= e[d]) && in_txn;
                checks++;
                if (busy_w[d] !== in_txn || req_ready_w[d] !== !in_txn) begin
                    errors++; $display("FAIL %s dut%0d k=%0d busy/req_ready got %b/%b want %b", tag, d, k, busy_w[d], req_ready_w[d], in_txn);
                end
                checks++;
                if (rden_w[d] !== (inr && !we && k == 0) || wren_w[d] !== (inr && we && k == 0)) begin
                    errors++; $display("FAIL %s dut%0d k=%0d rden/wren got %b/%b want %b/%b", tag, d, k, rden_w[d], wren_w[d], inr && !we && k == 0, inr && we && k == 0);
                end
                checks++;
                if (rsp_valid_w[d] !== exp_v) begin
                    errors++; $display("FAIL %s dut%0d k=%0d rsp_valid got %b want %b", tag, d, k, rsp_valid_w[d], exp_v);
                end
                checks++;
                if (rsp_err_w[d] !== (!inr && in_txn)) begin
                    errors++; $display("FAIL %s dut%0d k=%0d rsp_err got %b want %b", tag, d, k, rsp_err_w[d], !inr && in_txn);
                end
                if (exp_v) begin
                    checks++;
                    if (rsp_rdata_w[d] !== exp_rd) begin
                        errors++; $display("FAIL %s dut%0d k=%0d rsp_rdata got %h want %h", tag, d, k, rsp_rdata_w[d], exp_rd);
                    end
                end
                if (inr && in_txn) begin
                    checks++;
                    if (mem_address_w[d] !== addr[9:0] || mem_data_w[d] !== wdata) begin
                        errors++; $display("FAIL %s dut%0d k=%0d mem addr/data got %h/%h want %h/%h", tag, d, k, mem_address_w[d], mem_data_w[d], addr[9:0], wdata);
                    end
                end
            end
            // Garbage requests while both DUTs are busy must be ignored.
            rsp_ready = (k + 1 >= rdy_from);
            if (k + 1 <= min_c) begin
                req_valid = $urandom_range(0, 1);
                req_we    = $urandom_range(0, 1);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if (inr && we) ref_mem[addr[7:0]] = wdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; preload = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0012; req_wdata = 16'h1234; rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            preload = 1'b0;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({rden_w[d], wren_w[d], rsp_valid_w[d], rsp_err_w[d], busy_w[d]} !== 5'b0 ||
                    rsp_rdata_w[d] !== 16'h0 || mem_address_w[d] !== 10'h0 || mem_data_w[d] !== 16'h0) begin
                    errors++; $display("FAIL reset dut%0d outputs nonzero rden=%b wren=%b v=%b err=%b busy=%b rd=%h a=%h d=%h",
                        d, rden_w[d], wren_w[d], rsp_valid_w[d], rsp_err_w[d], busy_w[d], rsp_rdata_w[d], mem_address_w[d], mem_data_w[d]);
                end
            end
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready_w[d] !== 1'b1 || busy_w[d] !== 1'b0) begin
                errors++; $display("FAIL reset_release dut%0d req_ready/busy got %b/%b want 1/0", d, req_ready_w[d], busy_w[d]);
            end
        end
    endtask

    task automatic test_write_read;
        run_txn(1'b1, 16'h0012, 16'hBEEF, 0, "write_0x12");
        run_txn(1'b0, 16'h0012, 16'h0000, 0, "read_0x12");
    endtask

    task automatic test_error;
        run_txn(1'b0, 16'h0100, 16'h0000, 0, "err_read_0x100");
        run_txn(1'b1, 16'hFFFF, 16'h5555, 0, "err_write_0xffff");
        run_txn(1'b0, 16'h00FF, 16'h0000, 0, "read_0xff");
    endtask

    task automatic test_latency;
        run_txn(1'b1, 16'h0007, 16'h00A5, 0, "preload_7");
        run_txn(1'b0, 16'h0007, 16'h0000, 0, "read_7");
    endtask

    task automatic test_stall;
        run_txn(1'b0, 16'h0012, 16'h0000, 10, "stall_read");
        run_txn(1'b0, 16'h0300, 16'h0000, 6, "stall_err");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0007; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rden_w[d], wren_w[d], rsp_valid_w[d], busy_w[d]} !== 4'b0) begin
                errors++; $display("FAIL reset_mid dut%0d rden/wren/valid/busy got %b%b%b%b want 0000",
                    d, rden_w[d], wren_w[d], rsp_valid_w[d], busy_w[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rsp_valid_w[d] !== 1'b0) begin
                    errors++; $display("FAIL reset_mid_noresp dut%0d n=%0d rsp_valid got %b want 0", d, n, rsp_valid_w[d]);
                end
            end
        end
        run_txn(1'b0, 16'h0007, 16'h0000, 0, "read_7_after_reset");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 31));
            run_txn(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 8), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        test_reset();
        test_write_read();
        test_error();
        test_latency();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
